// File: rtl/conv_window_feeder_pkg.sv
// Shared defaults and helpers for the 3x3 streaming window feeder.
package conv_window_feeder_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int INPUT_SIZE     = 3;
  localparam int IMG_W_DEF      = 28;
  localparam int IMG_H_DEF      = 28;

  // A pixel closes a valid (unpadded) window once two full rows and columns precede it.
  function automatic logic window_done(input logic [31:0] row, input logic [31:0] col);
    return (row >= 32'd2) && (col >= 32'd2);
  endfunction

endpackage

// File: rtl/conv_window_feeder_line_buffer.sv
// Two-row line store: asynchronous read, synchronous read-before-write at one address.
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster-order pixel stream in, fully populated 3x3 windows out as three row vectors.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] win_row1 [INPUT_SIZE],
  output logic [DATA_WIDTH-1:0] win_row2 [INPUT_SIZE],
  output logic [DATA_WIDTH-1:0] win_row3 [INPUT_SIZE],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]        col_q, col_d, col_eff;
  logic [ROW_W-1:0]        row_q, row_d, row_eff;
  logic [DATA_WIDTH-1:0]   win_q [INPUT_SIZE][INPUT_SIZE];
  logic [DATA_WIDTH-1:0]   win_d [INPUT_SIZE][INPUT_SIZE];
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    accept;
  logic [2*DATA_WIDTH-1:0] lb_rdata, lb_wdata;
  logic [DATA_WIDTH-1:0]   top_old, mid_old;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is always (0,0), regardless of where the counters were.
  assign col_eff = in_sof ? '0 : col_q;
  assign row_eff = in_sof ? '0 : row_q;

  assign {top_old, mid_old} = lb_rdata;
  assign lb_wdata           = {mid_old, in_data};

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (2 * DATA_WIDTH)
  ) u_line_buffer (
    .clk_i   (clk_i),
    .we_i    (accept),
    .addr_i  (col_eff),
    .wdata_i (lb_wdata),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (accept) begin
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
      // Shift left every accept so columns 0..1 of each row prime the window.
      for (int r = 0; r < INPUT_SIZE; r++) begin
        for (int k = 0; k < INPUT_SIZE - 1; k++) begin
          win_d[r][k] = win_q[r][k+1];
        end
      end
      win_d[0][INPUT_SIZE-1] = top_old;
      win_d[1][INPUT_SIZE-1] = mid_old;
      win_d[2][INPUT_SIZE-1] = in_data;
      out_valid_d = window_done(32'(row_eff), 32'(col_eff));
      out_last_d  = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < INPUT_SIZE; r++) begin
        for (int k = 0; k < INPUT_SIZE; k++) begin
          win_q[r][k] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
    end
  end

  always_comb begin
    for (int k = 0; k < INPUT_SIZE; k++) begin
      win_row1[k] = win_q[0][k];
      win_row2[k] = win_q[1][k];
      win_row3[k] = win_q[2][k];
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Streaming 3x3 window generator sitting directly upstream of the CAE convolution core. It accepts one raster-order pixel per cycle and buffers the two previous image rows. It then presents each fully-populated 3x3 neighbourhood as three row vectors, which drive the core's `data_row1_in`/`data_row2_in`/`data_row3_in`. Windows are "valid" convolution only: no padding, stride 1.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: pixel width in bits.
- `IMG_W`, default 28: pixels per image row; legal range 3..1024.
- `IMG_H`, default 28: rows per frame; legal range 3..1024.

Ports:
- `clk_i`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` carries a pixel.
- `in_sof`  in  1  qualified by `in_valid`; marks the pixel as row 0, column 0.
- `in_data`  in  DATA_WIDTH  pixel value.
- `in_ready`  out  1  pixel accepted when `in_valid && in_ready`.
- `win_row1`  out  [`INPUT_SIZE`][DATA_WIDTH]  top window row (oldest image row).
- `win_row2`  out  [`INPUT_SIZE`][DATA_WIDTH]  middle window row.
- `win_row3`  out  [`INPUT_SIZE`][DATA_WIDTH]  bottom window row (current image row).
- `out_valid`  out  1  window outputs hold a valid window.
- `out_ready`  in  1  consumer takes the window when `out_valid && out_ready`.
- `out_last`  out  1  qualified by `out_valid`; marks the final window of the frame.

`INPUT_SIZE` is 3 for this block. Element [0] of each row is the leftmost column (col−2) and [2] is the current column.

## Operation
- Counters `col` (0..IMG_W−1) and `row` (0..IMG_H−1) advance on each accept.
  - `col` wraps to 0 and increments `row`.
  - After (IMG_H−1, IMG_W−1), both return to 0.
- `in_sof` on an accepted pixel forces that pixel to be (0,0), discarding any partial frame. The counters then continue from (0,1).
- Line buffer: depth IMG_W, entry = {top, mid}, addressed by `col`. On accept:
  - Read the entry at `col`, giving new window column {top_old, mid_old, in_data}.
  - Write back {mid_old, in_data}.
- The 3x3 window register shifts left by one column on each accept. The new column enters at [2].
- The accepted pixel completes a window iff `row >= 2 && col >= 2`. The last window of the frame is at (IMG_H−1, IMG_W−1).
- Line-buffer contents are not reset; the row/col gating masks stale data.

## Timing
- Reset: `out_valid`=0, `out_last`=0, `win_row*`=0, counters=0, window register=0, `in_ready`=1 in the cycle after reset deasserts.
- `in_ready = !out_valid || out_ready`, combinational. No combinational path from `in_valid` to `in_ready`.
- Latency: a window completed by a pixel accepted in cycle N appears on the outputs in cycle N+1 with `out_valid`=1.
- Output register update on accept:
  - `win_row*` load the shifted window.
  - `out_valid` and `out_last` load the completion flags of the accepted pixel.
  - The window register still shifts when no window is completed, so that columns 0..1 prime it.
- Without an accept, `out_valid` clears when `out_ready`=1, and otherwise holds.
- While `out_valid && !out_ready`, all outputs are held stable and `in_ready`=0 (stall).
- Simultaneous accept and consume: the new window replaces the old one in the same edge. Sustained throughput is 1 pixel/cycle.
- `rst` mid-frame: all state returns to reset values at the next edge. The next accepted pixel is treated as (0,0) whether or not `in_sof` is set.

## Structure
- `` `IMG_W `` and `` `IMG_H `` defaults go in `parameters.v` alongside `` `DATA_WIDTH `` and `` `INPUT_SIZE ``.
- Line storage lives in a sub-module, `line_buffer`:
  - Parameters: depth IMG_W, width 2·DATA_WIDTH.
  - Behaviour: asynchronous read, synchronous write at the same address, read-before-write.
- Window register, counters and handshake live in the top module.

## Test plan
Common setup: IMG_W=5, IMG_H=4, pixel value = row·16+col.
- **Basic frame:** stream 20 pixels with no stalls → exactly 6 windows.
  - First window appears one cycle after accepting pixel 0x22: row1={0x00,0x01,0x02}, row2={0x10,0x11,0x12}, row3={0x20,0x21,0x22}.
  - Last window has row3={0x32,0x33,0x34} and `out_last`=1.
- **Backpressure:** hold `out_ready`=0 for 3 cycles on the first window.
  - Outputs stay frozen and `in_ready`=0.
  - On release, the sequence continues with no window lost or duplicated; the second window has row3={0x21,0x22,0x23}.
- **Row wrap:** check that no window is emitted for pixels at col 0..1 of rows 2..3. The first window of row 3 has row1={0x10,0x11,0x12}.
- **Back-to-back frames:** two frames, the second with values +0x80 → second frame's first window row1={0x80,0x81,0x82}, with no stale first-frame data.
- **SOF resync:** assert `in_sof` at pixel (1,3) of a partial frame → counters restart. The next 20 pixels yield 6 correct windows.
- **Mid-frame reset:** pulse `rst` after 13 pixels → `out_valid`=0 in the next cycle. A fresh 20-pixel frame then yields 6 correct windows.
